// File: rtl/count_monitor.sv
// Lock/sequence monitor for an upstream 4-bit up counter, with saturating error and wrap counts.
// Optional macro SEQ_HOLD_EN: while LOCKED, a held count (inBus == prev) keeps the lock.
module count_monitor #(
   parameter int unsigned LOCK_LEN = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [3:0]       i_in_bus,
   input  logic             i_clear,
   output logic             o_locked,
   output logic             o_err_flag,
   output logic [CNT_W-1:0] o_err_count,
   output logic [CNT_W-1:0] o_wrap_count
);

   typedef enum logic [1:0] {
      StUnlocked,
      StLocking,
      StLocked,
      StFault
   } state_e;

   localparam logic [3:0]       LockLen = 4'(LOCK_LEN);
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

   state_e           r_state;
   state_e           w_state_next;
   logic [3:0]       r_prev;
   logic [3:0]       r_run;
   logic [3:0]       w_run_next;
   logic [3:0]       w_prev_inc;
   logic [3:0]       w_run_inc;
   logic             w_match;
   logic             w_hold;
   logic             w_err;
   logic             w_wrap;
   logic             r_locked;
   logic             r_err_flag;
   logic [CNT_W-1:0] r_err_count;
   logic [CNT_W-1:0] r_wrap_count;

   assign w_prev_inc = r_prev + 4'd1;
   assign w_run_inc  = r_run + 4'd1;
   assign w_match    = (i_in_bus == w_prev_inc);

`ifdef SEQ_HOLD_EN
   assign w_hold = (i_in_bus == r_prev);
`else
   assign w_hold = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_run_next   = r_run;
      w_err        = 1'b0;
      w_wrap       = 1'b0;
      unique case (r_state)
         StUnlocked: begin
            w_state_next = StLocking;
            w_run_next   = 4'd0;
         end
         StLocking: begin
            // A hold is a mismatch here even when SEQ_HOLD_EN is defined.
            if (w_match) begin
               w_run_next = w_run_inc;
               if (w_run_inc == LockLen) begin
                  w_state_next = StLocked;
               end
            end else begin
               w_run_next = 4'd0;
            end
         end
         StLocked: begin
            if (w_match) begin
               w_wrap = (r_prev == 4'd15) && (i_in_bus == 4'd0);
            end else if (!w_hold) begin
               w_state_next = StFault;
               w_err        = 1'b1;
            end
         end
         StFault: begin
            w_state_next = StLocking;
            w_run_next   = 4'd0;
         end
         default: begin
            w_state_next = StUnlocked;
            w_run_next   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StUnlocked;
         r_prev       <= 4'd0;
         r_run        <= 4'd0;
         r_locked     <= 1'b0;
         r_err_flag   <= 1'b0;
         r_err_count  <= '0;
         r_wrap_count <= '0;
      end else begin
         r_state    <= w_state_next;
         r_prev     <= i_in_bus;
         r_run      <= w_run_next;
         r_locked   <= (w_state_next == StLocked);
         r_err_flag <= w_err;
         // Clear wins over a same-cycle increment but leaves the FSM and errFlag alone.
         if (i_clear) begin
            r_err_count  <= '0;
            r_wrap_count <= '0;
         end else begin
            if (w_err && (r_err_count != CntMax)) begin
               r_err_count <= r_err_count + 1'b1;
            end
            if (w_wrap && (r_wrap_count != CntMax)) begin
               r_wrap_count <= r_wrap_count + 1'b1;
            end
         end
      end
   end

   assign o_locked     = r_locked;
   assign o_err_flag   = r_err_flag;
   assign o_err_count  = r_err_count;
   assign o_wrap_count = r_wrap_count;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor (LOCK_LEN=4, CNT_W=8); honours SEQ_HOLD_EN if defined.
module tb_count_monitor;

   logic       clk;
   logic       rst;
   logic [3:0] in_bus;
   logic       clear;
   logic       locked;
   logic       err_flag;
   logic [7:0] err_count;
   logic [7:0] wrap_count;

   int n_checks;
   int n_errors;
   logic [3:0] cur;

   count_monitor #(
      .LOCK_LEN(4),
      .CNT_W   (8)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_bus    (in_bus),
      .i_clear     (clear),
      .o_locked    (locked),
      .o_err_flag  (err_flag),
      .o_err_count (err_count),
      .o_wrap_count(wrap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Drive one sample, let the DUT take it, then settle before checking.
   task automatic tick(input logic [3:0] v);
      in_bus = v;
      cur    = v;
      @(posedge clk);
      #1;
   endtask

   // From LOCKED: one mismatch, the FAULT cycle, then four matches to relock.
   task automatic err_relock();
      tick(cur + 4'd3);
      tick(cur + 4'd1);
      for (int k = 0; k < 4; k++) tick(cur + 4'd1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      clear    = 1'b0;
      in_bus   = 4'd0;
      cur      = 4'd0;
      tick(4'd7);
      tick(4'd7);
      check("reset_locked", locked, 0);
      check("reset_errflag", err_flag, 0);
      check("reset_errcnt", err_count, 0);
      check("reset_wrapcnt", wrap_count, 0);
      rst = 1'b0;

      // Initial lock: 0 captured, 1..4 are the four matches.
      tick(4'd0);
      tick(4'd1);
      tick(4'd2);
      tick(4'd3);
      check("lock_not_yet", locked, 0);
      tick(4'd4);
      check("lock_after_4", locked, 1);
      tick(4'd5);
      check("lock_hold", locked, 1);
      check("lock_errflag", err_flag, 0);
      check("lock_errcnt", err_count, 0);

      // Jump 6 -> 9, then recover with 10..14.
      tick(4'd6);
      tick(4'd9);
      check("jump_errflag", err_flag, 1);
      check("jump_errcnt", err_count, 1);
      check("jump_locked", locked, 0);
      tick(4'd10);
      check("fault_errflag_1cyc", err_flag, 0);
      check("fault_locked", locked, 0);
      tick(4'd11);
      tick(4'd12);
      tick(4'd13);
      check("relock_not_yet", locked, 0);
      tick(4'd14);
      check("relock", locked, 1);

      // Wrap 15 -> 0 while locked.
      tick(4'd15);
      check("wrap_before", wrap_count, 0);
      tick(4'd0);
      check("wrap_count", wrap_count, 1);
      check("wrap_locked", locked, 1);
      check("wrap_errflag", err_flag, 0);
      tick(4'd1);
      check("wrap_after_locked", locked, 1);

      // Held count 7,7,8.
      for (int v = 2; v <= 7; v++) tick(4'(v));
      tick(4'd7);
`ifdef SEQ_HOLD_EN
      check("hold_errflag", err_flag, 0);
      check("hold_errcnt", err_count, 1);
      check("hold_locked", locked, 1);
      tick(4'd8);
      check("hold_after_locked", locked, 1);
`else
      check("hold_errflag", err_flag, 1);
      check("hold_errcnt", err_count, 2);
      check("hold_locked", locked, 0);
      tick(4'd8);
      check("hold_after_locked", locked, 0);
`endif
      for (int v = 9; v <= 12; v++) tick(4'(v));
      check("hold_relock", locked, 1);

      // Clear in the same cycle as a mismatch.
      clear = 1'b1;
      tick(4'd5);
      clear = 1'b0;
      check("clr_errflag", err_flag, 1);
      check("clr_errcnt", err_count, 0);
      check("clr_wrapcnt", wrap_count, 0);
      check("clr_locked", locked, 0);
      tick(4'd6);
      for (int v = 7; v <= 10; v++) tick(4'(v));
      check("clr_relock", locked, 1);

      // Build errCount=3, wrapCount=2 then reset while locked.
      for (int v = 11; v <= 15; v++) tick(4'(v));
      tick(4'd0);
      tick(4'd5);
      tick(4'd6);
      for (int v = 7; v <= 10; v++) tick(4'(v));
      for (int v = 11; v <= 15; v++) tick(4'(v));
      tick(4'd0);
      tick(4'd5);
      tick(4'd6);
      for (int v = 7; v <= 10; v++) tick(4'(v));
      tick(4'd3);
      tick(4'd4);
      for (int v = 5; v <= 8; v++) tick(4'(v));
      check("pre_rst_errcnt", err_count, 3);
      check("pre_rst_wrapcnt", wrap_count, 2);
      check("pre_rst_locked", locked, 1);
      rst = 1'b1;
      clear = 1'b1;
      tick(4'd9);
      rst = 1'b0;
      clear = 1'b0;
      check("rst_locked", locked, 0);
      check("rst_errflag", err_flag, 0);
      check("rst_errcnt", err_count, 0);
      check("rst_wrapcnt", wrap_count, 0);

      // Relock with a break in LOCKING: run restarts, no error counted.
      tick(4'd0);
      tick(4'd1);
      tick(4'd2);
      tick(4'd7);
      check("locking_no_err", err_count, 0);
      check("locking_no_flag", err_flag, 0);
      tick(4'd8);
      tick(4'd9);
      tick(4'd10);
      check("locking_run_reset", locked, 0);
      tick(4'd11);
      check("locking_relock", locked, 1);

      // Saturate errCount.
      for (int i = 0; i < 255; i++) err_relock();
      check("sat_reach", err_count, 255);
      check("sat_locked", locked, 1);
      tick(cur + 4'd5);
      check("sat_errflag", err_flag, 1);
      check("sat_errcnt", err_count, 255);
      tick(cur + 4'd1);
      check("sat_errflag_1cyc", err_flag, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 4: consecutive correct increments required to lock (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8: width of errCount and wrapCount.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port inBus, input, 4: count value from upstream 4-bit synchronous up counter, sampled every rising edge.
REQ-006 SHALL have port clear, input, 1: synchronous clear of errCount and wrapCount.
REQ-007 SHALL have port locked, output, 1: high while the FSM is in LOCKED.
REQ-008 SHALL have port errFlag, output, 1: one-cycle pulse per sequence error detected in LOCKED.
REQ-009 SHALL have port errCount, output, CNT_W: saturating count of sequence errors.
REQ-010 SHALL have port wrapCount, output, CNT_W: saturating count of 15->0 wraps seen while LOCKED.

Function
REQ-011 SHALL hold a registered copy prev of the last sampled inBus, updated every non-reset cycle.
REQ-012 SHALL define "match" as inBus == (prev + 1) mod 16, i.e. 4-bit wrap, 15 followed by 0 is a match.
REQ-013 SHALL implement FSM states UNLOCKED, LOCKING, LOCKED, FAULT.
REQ-014 UNLOCKED: capture inBus into prev, clear run counter, go to LOCKING next cycle unconditionally.
REQ-015 LOCKING: on match, increment run; when run reaches LOCK_LEN, go to LOCKED. On mismatch, set run to 0 and stay in LOCKING. No error is counted in LOCKING.
REQ-016 LOCKED: on match, stay. On mismatch, go to FAULT, pulse errFlag, increment errCount.
REQ-017 FAULT: lasts exactly one cycle, then goes to LOCKING with run = 0; inBus sampled during FAULT only updates prev.
REQ-018 SHALL drive locked, errFlag, errCount and wrapCount from registers with no combinational path from inBus.
REQ-019 errFlag SHALL be high only in the cycle following the edge at which the mismatch was sampled.
REQ-020 wrapCount SHALL increment when, in LOCKED, prev == 15 and inBus == 0.
REQ-021 errCount and wrapCount SHALL saturate at 2^CNT_W - 1 and never wrap.
REQ-022 clear SHALL zero both counters and take priority over a same-cycle increment. clear SHALL NOT affect the FSM, prev or errFlag.
REQ-023 locked SHALL deassert in the cycle errFlag asserts.

Reset
REQ-024 On rst, the following SHALL take effect at the next edge: state = UNLOCKED, prev = 0, run = 0, locked = 0, errFlag = 0, errCount = 0, wrapCount = 0.
REQ-025 rst SHALL take priority over clear and all other updates, including mid-LOCKED or in FAULT.

Configuration
REQ-026 Macro SEQ_HOLD_EN, defined: in LOCKED, inBus == prev (upstream counter held) SHALL be treated as a match for staying LOCKED. It SHALL NOT count as an error and SHALL NOT count as an increment.
REQ-027 Macro SEQ_HOLD_EN, not defined: inBus == prev in LOCKED SHALL be a mismatch, handled per REQ-016.
REQ-028 SEQ_HOLD_EN SHALL NOT change LOCKING behaviour. A hold during LOCKING resets run to 0.

Verification (LOCK_LEN=4, CNT_W=8)
REQ-029 Reset, then inBus 0,1,2,3,4,5 -> locked rises after the 4 match is processed (4th correct increment), errFlag stays 0, errCount=0.
REQ-030 Locked, inBus 13,14,15,0,1 -> wrapCount 0->1, errFlag never asserts, locked stays 1.
REQ-031 Locked at 6, then inBus 9 -> errFlag high exactly one cycle, errCount=1, locked=0; then 10,11,12,13,14 -> locked reasserts after 4 matches.
REQ-032 Locked, inBus 7,7,8 -> without SEQ_HOLD_EN: errCount=1, locked drops. With SEQ_HOLD_EN: errCount=0, locked stays 1.
REQ-033 errCount=255 plus a mismatch -> errCount stays 255 and errFlag pulses. clear asserted in the same cycle as a mismatch -> errCount=0 next cycle and errFlag still pulses.
REQ-034 rst asserted one cycle while LOCKED with errCount=3, wrapCount=2 -> next cycle all outputs 0 and state UNLOCKED. Relock requires 4 matches again.
